uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter FIFO_DATA_ADDR, default 16'hFF04, CPU write-data address.
REQ-003 SHALL have parameter FIFO_STAT_ADDR, default 16'hFF05, CPU status address.
REQ-004 SHALL have port clk input 1: clock, all state on rising edge.
REQ-005 SHALL have port reset input 1: reset, asynchronous, active-high.
REQ-006 SHALL have port addr input 16: CPU bus address.
REQ-007 SHALL have port data_in input 8: CPU write data.
REQ-008 SHALL have port data_out output 8: CPU read data, combinational.
REQ-009 SHALL have port mem_read input 1: CPU read strobe, one cycle per access.
REQ-010 SHALL have port mem_write input 1: CPU write strobe, one cycle per access.
REQ-011 SHALL have port uart_tx_ready input 1: downstream UART transmitter idle (status bit0, i.e. not busy).
REQ-012 SHALL have port uart_wr output 1: one-cycle write strobe into UART TX register (FF00).
REQ-013 SHALL have port uart_wdata output 8: byte presented with uart_wr.

Function
REQ-014 SHALL push data_in when mem_write=1 and addr==FIFO_DATA_ADDR and FIFO not full.
REQ-015 SHALL drop a push while full and set sticky overflow flag; FIFO contents/count unchanged.
REQ-016 SHALL hold count 0..DEPTH, width clog2(DEPTH)+1; pointers clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 SHALL, on simultaneous push and pop, perform both; count unchanged; push allowed when full only if pop same cycle is not assumed (full blocks push regardless).
REQ-018 SHALL run drain FSM with states IDLE, ISSUE, HOLDOFF.
REQ-019 IDLE -> ISSUE when count!=0 and uart_tx_ready=1, else stay IDLE.
REQ-020 ISSUE: uart_wr=1 for exactly this cycle, uart_wdata=head entry, head popped at cycle end; -> HOLDOFF.
REQ-021 HOLDOFF: uart_wr=0, uart_tx_ready ignored for this one cycle (UART busy flag rises one cycle after write); -> IDLE.
REQ-022 SHALL give minimum push-to-uart_wr latency of 2 cycles (push edge, IDLE decision edge, ISSUE cycle) when FIFO empty and UART ready.
REQ-023 SHALL keep uart_wdata equal to current head entry in all states (0 when empty).
REQ-024 data_out SHALL equal status byte when addr==FIFO_STAT_ADDR, else 8'h00.
REQ-025 Status byte: bit7 overflow, bit6 full, bit5 empty, bits4:0 count saturated to 31 (DEPTH>31 reports 31).
REQ-026 SHALL clear overflow on the cycle after mem_read at FIFO_STAT_ADDR; overflow set in same cycle wins (stays 1).
REQ-027 SHALL ignore mem_read/mem_write at all other addresses.

Reset
REQ-028 Reset SHALL force FSM=IDLE, pointers=0, count=0, overflow=0, uart_wr=0 immediately, independent of clk.
REQ-029 Reset mid-ISSUE SHALL abort the strobe; queued bytes lost; FIFO storage array need not be cleared.

Structure
REQ-030 Shared package SHALL hold address constants (UART_TX FF00, UART_RX FF01, UART_STATUS FF02, FIFO_DATA FF04, FIFO_STAT FF05) and drain-FSM state enum.
REQ-031 One sub-module SHALL be natural: sync_fifo (parameterised width/depth, push/pop/full/empty/count); FSM and bus decode in top.

Verification
REQ-032 Reset, write 8'h41 to FF04, uart_tx_ready=1 -> uart_wr pulses once 2 cycles later with uart_wdata=8'h41; status then 8'h20.
REQ-033 uart_tx_ready=0, write 16 bytes 0x00..0x0F -> status 8'h50; 17th write 0xFF -> status 8'hD0, read again -> 8'h50.
REQ-034 From full, raise uart_tx_ready and toggle it low 1 cycle after each uart_wr for 10 cycles -> bytes emitted in order 0x00..0x0F, no strobe in HOLDOFF, uart_wr never on consecutive cycles.
REQ-035 Push to FF04 in same cycle as ISSUE pop with count=5 -> count stays 5, pointer wrap verified across index 15 -> 0.
REQ-036 Assert reset during ISSUE with count=3 -> uart_wr=0 same cycle, status 8'h20 after release, no further strobes.
REQ-037 Writes to FF00/FF03 and reads of FF04 -> no FIFO change, data_out=8'h00.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit FIFO: CPU bus map,
// drain state machine encoding and the status byte formatter.
package uart_tx_fifo_pkg;

    // CPU-visible register addresses of the UART block and its TX FIFO
    localparam logic [15:0] ADDR_UART_TX     = 16'hFF00;
    localparam logic [15:0] ADDR_UART_RX     = 16'hFF01;
    localparam logic [15:0] ADDR_UART_STATUS = 16'hFF02;
    localparam logic [15:0] ADDR_FIFO_DATA   = 16'hFF04;
    localparam logic [15:0] ADDR_FIFO_STAT   = 16'hFF05;

    // Drain state machine: wait for data+idle UART, strobe one byte, then
    // wait one cycle for the UART busy flag to become valid.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } drain_state_t;

    // Status byte: {overflow, full, empty, count saturated to 5 bits}
    function automatic logic [7:0] status_byte(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [8:0] count
    );
        logic [4:0] sat;
        if (count > 9'd31) begin
            sat = 5'd31;
        end else begin
            sat = count[4:0];
        end
        return {ovf, full, empty, sat};
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count. Push while full and pop while
// empty are ignored. Read data is the head entry, forced to zero when empty.
module uart_tx_fifo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_rdata   = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written on accepted pushes, deliberately not reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and count; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-facing transmit FIFO in front of the UART TX register. The CPU writes
// bytes to the data address; a drain FSM forwards them one at a time to the
// UART whenever it reports idle. A status byte reports overflow/full/empty/count.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int          DEPTH          = 16,
    parameter logic [15:0] FIFO_DATA_ADDR = ADDR_FIFO_DATA,
    parameter logic [15:0] FIFO_STAT_ADDR = ADDR_FIFO_STAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        uart_tx_ready,
    output logic        uart_wr,
    output logic [7:0]  uart_wdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_t  r_state;
    logic          r_uart_wr;
    logic          r_overflow;
    logic          w_push_req;
    logic          w_stat_rd;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;

    assign w_push_req = mem_write && (addr == FIFO_DATA_ADDR);
    assign w_stat_rd  = mem_read && (addr == FIFO_STAT_ADDR);
    // The only path into ISSUE requires a non-empty FIFO, so the pop is safe
    assign w_pop      = (r_state == ST_ISSUE);
    assign uart_wr    = r_uart_wr;
    assign uart_wdata = w_head;

    uart_tx_fifo_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_wdata (data_in),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Drain FSM with registered UART write strobe (high only in ISSUE)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_uart_wr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((w_count != {CW{1'b0}}) && uart_tx_ready) begin
                        r_state   <= ST_ISSUE;
                        r_uart_wr <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_uart_wr <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_state   <= ST_HOLDOFF;
                    r_uart_wr <= 1'b0;
                end
                ST_HOLDOFF: begin
                    r_state   <= ST_IDLE;
                    r_uart_wr <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_uart_wr <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: set by a push into a full FIFO, cleared by a status read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_stat_rd) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    // CPU read mux: status byte at the status address, zero elsewhere
    always_comb begin
        data_out = 8'h00;
        if (addr == FIFO_STAT_ADDR) begin
            data_out = status_byte(r_overflow, w_full, w_empty, 9'(w_count));
        end else begin
            data_out = 8'h00;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected UART bytes and
// status bytes; a monitor compares them as the DUT presents strobes/reads.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        mem_read;
    logic        mem_write;
    logic        uart_tx_ready;
    logic        uart_wr;
    logic [7:0]  uart_wdata;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          wr_seen     = 0;
    int          exp_strobes = 0;
    logic [7:0]  q_tx[$];
    logic [7:0]  q_stat[$];

    uart_tx_fifo #(
        .DEPTH          (16),
        .FIFO_DATA_ADDR (16'hFF04),
        .FIFO_STAT_ADDR (16'hFF05)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .uart_tx_ready (uart_tx_ready),
        .uart_wr       (uart_wr),
        .uart_wdata    (uart_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr      = a;
        data_in   = d;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        addr      = 16'h0000;
    endtask

    // Write to the FIFO data address and expect the byte on the UART later
    task automatic push_byte(input logic [7:0] d);
        q_tx.push_back(d);
        exp_strobes++;
        cpu_write(16'hFF04, d);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        addr     = a;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        addr     = 16'h0000;
    endtask

    task automatic read_stat(input logic [7:0] exp);
        q_stat.push_back(exp);
        cpu_read(16'hFF05);
    endtask

    // Let the FSM drain the queue with uart_tx_ready held high
    task automatic drain_all(input string name);
        int budget;
        budget = 0;
        uart_tx_ready = 1'b1;
        while (q_tx.size() != 0 && budget < 300) begin
            tick(1);
            budget++;
        end
        chk(name, q_tx.size(), 0);
    endtask

    // Monitor: compare strobed bytes and CPU reads against the queues
    initial begin
        logic prev_wr;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wr = 1'b0;
            end else begin
                if (uart_wr) begin
                    wr_seen++;
                    chk("no_back_to_back_wr", prev_wr, 1'b0);
                    if (q_tx.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_strobe: got byte %0h, expected no strobe", uart_wdata);
                    end else begin
                        chk("tx_byte", uart_wdata, q_tx.pop_front());
                    end
                end
                if (mem_read) begin
                    if (addr == 16'hFF05) begin
                        if (q_stat.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_status_read: got %0h, expected none queued", data_out);
                        end else begin
                            chk("status", data_out, q_stat.pop_front());
                        end
                    end else begin
                        chk("data_out_zero", data_out, 8'h00);
                    end
                end
                prev_wr = uart_wr;
            end
        end
    end

    // Global time limit so the bench can never hang
    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int n;
        reset         = 1'b1;
        addr          = 16'h0000;
        data_in       = 8'h00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        uart_tx_ready = 1'b1;
        tick(3);
        chk("reset_uart_wr", uart_wr, 1'b0);
        chk("reset_wdata", uart_wdata, 8'h00);
        reset = 1'b0;
        tick(1);
        read_stat(8'h20);

        // Single byte: strobe two cycles after the write
        push_byte(8'h41);
        chk("latency_wr_low", uart_wr, 1'b0);
        tick(1);
        chk("latency_wr_high", uart_wr, 1'b1);
        chk("latency_wdata", uart_wdata, 8'h41);
        tick(4);
        read_stat(8'h20);

        // Fill with UART busy, then overflow and clear-on-read
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
        end
        read_stat(8'h50);
        cpu_write(16'hFF04, 8'hFF);
        read_stat(8'hD0);
        read_stat(8'h50);

        // Drain from full, dropping ready in the cycle after each strobe
        uart_tx_ready = 1'b1;
        n = 0;
        while (q_tx.size() != 0 && n < 300) begin
            tick(1);
            n++;
            if (uart_wr) begin
                tick(1);
                uart_tx_ready = 1'b0;
                tick(1);
                uart_tx_ready = 1'b1;
            end
        end
        chk("drain_full_done", q_tx.size(), 0);
        tick(3);
        read_stat(8'h20);

        // Pointers now at 1: fill 14 (to index 14), drain 9 -> count 5
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            push_byte(8'hE0 + 8'(i));
        end
        uart_tx_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 300 && n < 9; c++) begin
            tick(1);
            if (uart_wr) begin
                n++;
                if (n == 9) begin
                    uart_tx_ready = 1'b0;
                end
            end
        end
        chk("partial_drain_count", n, 9);
        tick(3);
        read_stat(8'h05);
        // Push in the same cycle as the ISSUE pop
        uart_tx_ready = 1'b1;
        tick(1);
        chk("issue_cycle_wr", uart_wr, 1'b1);
        uart_tx_ready = 1'b0;
        push_byte(8'hC0);
        read_stat(8'h05);
        push_byte(8'hC1);
        read_stat(8'h06);
        drain_all("drain_wrap_done");
        tick(3);
        read_stat(8'h20);

        // Reset asserted during ISSUE aborts strobe and flushes the queue
        uart_tx_ready = 1'b0;
        cpu_write(16'hFF04, 8'hD0);
        cpu_write(16'hFF04, 8'hD1);
        cpu_write(16'hFF04, 8'hD2);
        read_stat(8'h03);
        uart_tx_ready = 1'b1;
        tick(1);
        chk("pre_reset_issue_wr", uart_wr, 1'b1);
        reset = 1'b1;
        #1;
        chk("reset_aborts_wr", uart_wr, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
        read_stat(8'h20);
        tick(10);

        // Other addresses: no FIFO effect, zero read data
        cpu_read(16'hFF04);
        cpu_write(16'hFF00, 8'h55);
        cpu_write(16'hFF03, 8'h66);
        cpu_read(16'hFF00);
        tick(5);
        read_stat(8'h20);

        tick(3);
        chk("strobe_total", wr_seen, exp_strobes);
        chk("tx_queue_empty", q_tx.size(), 0);
        chk("stat_queue_empty", q_stat.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
